// File: rtl/dim_mem_arbiter_pkg.sv
// Shared types and constants for the dimming-memory arbiter.
// Slot types, the protected command-word address range, and default widths.
package dim_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 16;

  // SPI init/on/off command words live at the top of the dimming memory.
  localparam int unsigned PROT_ADDR_LO = 'h1F8;
  localparam int unsigned PROT_ADDR_HI = 'h1FF;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE,
    SLOT_FORCE
  } slot_t;

  function automatic logic in_prot_range(input int unsigned addr);
    return (addr >= PROT_ADDR_LO) && (addr <= PROT_ADDR_HI);
  endfunction

endpackage

// File: rtl/dim_wr_fifo.sv
// Write buffer for the dimming-memory arbiter.
// In-order FIFO, power-of-two depth, registered full flag, head visible combinationally.
module dim_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 25,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic [CW-1:0]    w_count_nxt;

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !i_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!i_push && i_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Pointers wrap naturally at PW bits; full is registered from next occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  // Entry storage needs no reset; occupancy tracking makes stale data invisible.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/dim_mem_arbiter.sv
// Dimming-memory arbiter: one single-port memory slot per cycle shared between
// SPI sequencer reads and buffered dimming-algorithm writes, with anti-starvation.
// Optional feature: define DIM_ARB_PROTECT_EN to discard writes to the
// command-word range and flag them on wr_err.
module dim_mem_arbiter
  import dim_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  slot_t                    w_slot;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [CW-1:0]            w_fifo_count;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic [SW-1:0]            r_starve;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic                     r_mem_we;
  logic [DATA_W-1:0]        r_mem_wdata;
  logic                     r_rd_p1;
  logic                     r_rd_valid;

  dim_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_wr_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  ({wr_addr, wr_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign wr_ready = !w_fifo_full;

`ifdef DIM_ARB_PROTECT_EN
  logic w_accept;
  logic w_prot;
  logic r_wr_err;

  assign w_accept = wr_req && wr_ready;
  assign w_prot   = in_prot_range(32'(wr_addr));
  assign w_push   = w_accept && !w_prot;

  // Sticky flag for accepted writes that target the command-word range.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_err <= 1'b0;
    end else if (w_accept && w_prot) begin
      r_wr_err <= 1'b1;
    end
  end

  assign wr_err = r_wr_err;
`else
  assign w_push = wr_req && wr_ready;
  assign wr_err = 1'b0;
`endif

  // Slot priority: starved write, then read, then ordinary write, else idle.
  always_comb begin
    w_slot = SLOT_IDLE;
    if (!w_fifo_empty && (r_starve == SW'(STARVE_MAX))) begin
      w_slot = SLOT_FORCE;
    end else if (rd_req) begin
      w_slot = SLOT_READ;
    end else if (!w_fifo_empty) begin
      w_slot = SLOT_WRITE;
    end
  end

  assign w_pop  = (w_slot == SLOT_FORCE) || (w_slot == SLOT_WRITE);
  assign rd_gnt = (w_slot == SLOT_READ);

  // Count cycles a buffered write loses to reads, saturating at STARVE_MAX.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if ((w_fifo_count == '0) || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != SW'(STARVE_MAX)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Register the winning access onto the memory port; idle holds the address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (w_slot)
        SLOT_FORCE, SLOT_WRITE: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_head[ADDR_W+DATA_W-1:DATA_W];
          r_mem_wdata <= w_head[DATA_W-1:0];
        end
        SLOT_READ: begin
          r_mem_we   <= 1'b0;
          r_mem_addr <= rd_addr;
        end
        default: begin
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage read strobe: address cycle, then memory data cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_p1    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_p1    <= rd_gnt;
      r_rd_valid <= r_rd_p1;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rd_valid  = r_rd_valid;
  // Memory data arrives in the strobe cycle itself, so it is passed through.
  assign rd_data   = r_rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_dim_mem_arbiter.sv
// Self-checking bench for dim_mem_arbiter (default parameters).
// Honours DIM_ARB_PROTECT_EN when the design is built with it.
module tb_dim_mem_arbiter;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned STARVE = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rd_req;
  logic [8:0]  rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        wr_err;

  int checks   = 0;
  int failures = 0;

  dim_mem_arbiter #(
    .ADDR_W     (9),
    .DATA_W     (16),
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (STARVE)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .wr_err    (wr_err)
  );

  always #5 clock = ~clock;

  // Single-port memory: initial pattern 0xC000|addr, data one cycle after address.
  logic [15:0] tbmem [512];
  bit          mem_init_done;
  always @(posedge clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 512; i++) tbmem[i] <= 16'hC000 | 16'(i);
      mem_init_done <= 1'b1;
    end else begin
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
      mem_rdata <= tbmem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_prot(input logic [8:0] a);
`ifdef DIM_ARB_PROTECT_EN
    return a >= 9'h1F8;
`else
    return (a == a) && 1'b0;
`endif
  endfunction

  // Behavioural model: pending-write queue, starvation count, shadow memory.
  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  initial begin : model
    wr_t         q[$];
    wr_t         h;
    int          s;
    int          sz;
    bit          e_we, e_err, e_ready;
    logic [8:0]  e_addr;
    logic [15:0] e_wd;
    bit          p1_v, p2_v, f, r, w;
    logic [8:0]  p1_a;
    logic [15:0] p2_d;
    logic [15:0] shadow [512];
    for (int i = 0; i < 512; i++) shadow[i] = 16'hC000 | 16'(i);
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        q.delete();
        s = 0; e_we = 0; e_err = 0; e_addr = '0; e_wd = '0;
        p1_v = 0; p2_v = 0; p2_d = '0; p1_a = '0;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_wr_err", 32'(wr_err), 0);
      end else begin
        sz      = q.size();
        e_ready = (sz != DEPTH);
        chk("m_wr_ready", 32'(wr_ready), 32'(e_ready));
        chk("m_mem_we", 32'(mem_we), 32'(e_we));
        chk("m_mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("m_mem_wdata", 32'(mem_wdata), 32'(e_wd));
        chk("m_wr_err", 32'(wr_err), 32'(e_err));
        chk("m_rd_valid", 32'(rd_valid), 32'(p2_v));
        if (p2_v) chk("m_rd_data", 32'(rd_data), 32'(p2_d));
        f = (sz > 0) && (s == STARVE);
        r = !f && rd_req;
        w = !f && !r && (sz > 0);
        chk("m_rd_gnt", 32'(rd_gnt), 32'(r));
        // read data seen by last cycle's grant, then shift the read pipe
        p2_v = p1_v;
        p2_d = shadow[p1_a];
        p1_v = r;
        p1_a = rd_addr;
        if (f || w) begin
          h = q.pop_front();
          e_we = 1; e_addr = h.a; e_wd = h.d;
          shadow[h.a] = h.d;
        end else begin
          e_we = 0;
          if (r) e_addr = rd_addr;
        end
        if (sz == 0 || f || w) s = 0;
        else if (s < STARVE) s++;
        if (wr_req && e_ready) begin
          if (is_prot(wr_addr)) e_err = 1;
          else q.push_back('{a: wr_addr, d: wr_data});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin : stim
    int n;
    reset_n = 1'b0;
    rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
    step(3);
    chk("lit_rst_wr_ready", 32'(wr_ready), 1);
    chk("lit_rst_mem_we", 32'(mem_we), 0);
    reset_n = 1'b1;
    step(2);

    // single write, no reads: memory write two cycles after the push
    wr_req = 1; wr_addr = 9'h010; wr_data = 16'h1234;
    chk("lit_A_ready", 32'(wr_ready), 1);
    step(1);
    wr_req = 0;
    chk("lit_A_we_p1", 32'(mem_we), 0);
    step(1);
    chk("lit_A_we", 32'(mem_we), 1);
    chk("lit_A_addr", 32'(mem_addr), 32'h010);
    chk("lit_A_data", 32'(mem_wdata), 32'h1234);
    step(2);

    // continuous reads with one buffered write: 8 grants, forced write, resume
    rd_req = 1; rd_addr = 9'h005;
    wr_req = 1; wr_addr = 9'h020; wr_data = 16'hBEEF;
    step(1);
    wr_req = 0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      n += int'(rd_gnt);
      rd_addr = 9'(i);
      step(1);
    end
    chk("lit_B_grants", 32'(n), 8);
    chk("lit_B_force_gnt", 32'(rd_gnt), 0);
    step(1);
    chk("lit_B_resume_gnt", 32'(rd_gnt), 1);
    chk("lit_B_we", 32'(mem_we), 1);
    chk("lit_B_addr", 32'(mem_addr), 32'h020);
    chk("lit_B_data", 32'(mem_wdata), 32'hBEEF);
    rd_req = 0;
    step(3);

    // fill the buffer while reads hold the slot; 5th write waits for a pop
    rd_req = 1; rd_addr = 9'h040;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1; wr_addr = 9'h030 + 9'(i); wr_data = 16'hA000 + 16'(i);
      step(1);
    end
    wr_addr = 9'h034; wr_data = 16'hA004;
    chk("lit_C_full", 32'(wr_ready), 0);
    step(5);
    chk("lit_C_still_full", 32'(wr_ready), 0);
    chk("lit_C_force", 32'(rd_gnt), 0);
    step(1);
    chk("lit_C_ready_again", 32'(wr_ready), 1);
    step(1);
    wr_req = 0; rd_req = 0;
    step(8);

    // three back-to-back reads
    rd_req = 1; rd_addr = 9'h000;
    step(1);
    rd_addr = 9'h00C;
    step(1);
    rd_addr = 9'h060;
    chk("lit_D_v0", 32'(rd_valid), 1);
    chk("lit_D_d0", 32'(rd_data), 32'hC000);
    step(1);
    rd_req = 0;
    chk("lit_D_v1", 32'(rd_valid), 1);
    chk("lit_D_d1", 32'(rd_data), 32'hC00C);
    step(1);
    chk("lit_D_v2", 32'(rd_valid), 1);
    chk("lit_D_d2", 32'(rd_data), 32'hC060);
    step(1);
    chk("lit_D_v3", 32'(rd_valid), 0);
    step(2);

    // write to the command-word range
    wr_req = 1; wr_addr = 9'h1FE; wr_data = 16'h7777;
    step(1);
    wr_req = 0;
`ifdef DIM_ARB_PROTECT_EN
    chk("lit_E_err", 32'(wr_err), 1);
    step(1);
    chk("lit_E_no_we", 32'(mem_we), 0);
    step(3);
    chk("lit_E_err_sticky", 32'(wr_err), 1);
`else
    chk("lit_E_err0", 32'(wr_err), 0);
    step(1);
    chk("lit_E_we", 32'(mem_we), 1);
    chk("lit_E_addr", 32'(mem_addr), 32'h1FE);
    chk("lit_E_err0b", 32'(wr_err), 0);
    step(3);
`endif

    // reset with three writes buffered: they must never reach memory
    rd_req = 1; rd_addr = 9'h050;
    for (int i = 0; i < 3; i++) begin
      wr_req = 1; wr_addr = 9'h070 + 9'(i); wr_data = 16'hD000 + 16'(i);
      step(1);
    end
    wr_req = 0;
    reset_n = 1'b0;
    #1;
    chk("lit_F_ready", 32'(wr_ready), 1);
    chk("lit_F_we", 32'(mem_we), 0);
    rd_req = 0;
    step(1);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n += int'(mem_we);
      step(1);
    end
    chk("lit_F_no_we", 32'(n), 0);
    wr_req = 1; wr_addr = 9'h080; wr_data = 16'h1111;
    step(1);
    wr_req = 0;
    step(1);
    chk("lit_F_new_we", 32'(mem_we), 1);
    chk("lit_F_new_addr", 32'(mem_addr), 32'h080);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
